// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the memory copy/fill engine.
package mem_copy_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  // Transfer modes as latched from the fill input.
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy / constant fill engine driving both ports of a dual-port SRAM.
// Port A streams reads, port B writes one cycle behind, one word per cycle.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic                  mem_we_a,
  output logic [DATA_WIDTH-1:0] mem_data_a,
  input  logic [DATA_WIDTH-1:0] mem_q_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic                  mem_we_b,
  output logic [DATA_WIDTH-1:0] mem_data_b
);

  localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
  logic [ADDR_WIDTH-1:0]   remain_q, remain_d;
  logic                    desc_q, desc_d;
  logic                    mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   fill_q, fill_d;
  logic                    we_b_q, we_b_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [ADDR_WIDTH-1:0]   dist_c;
  logic [ADDR_WIDTH-1:0]   len_m1_c;
  logic                    descending_c;

  // One step along the transfer direction, wrapping at the memory boundary.
  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic dn);
    return dn ? (a - ADDR_WIDTH'(1)) : (a + ADDR_WIDTH'(1));
  endfunction

  // Overlap detection: a destination just ahead of the source must be copied top-down.
  always_comb begin
    dist_c       = dst_addr - src_addr;
    len_m1_c     = ADDR_WIDTH'(length - LEN_WIDTH'(1));
    descending_c = (fill == MODE_COPY) && (dist_c != '0) && (LEN_WIDTH'(dist_c) < length);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    dst_d    = dst_q;
    addr_b_d = addr_b_q;
    remain_d = remain_q;
    desc_d   = desc_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    we_b_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = fill ? MODE_FILL : MODE_COPY;
          fill_d = fill_value;
          if (length == '0) begin
            state_d = ST_LAST;
          end else begin
            desc_d   = descending_c;
            addr_a_d = descending_c ? (src_addr + len_m1_c) : src_addr;
            dst_d    = descending_c ? (dst_addr + len_m1_c) : dst_addr;
            remain_d = len_m1_c;
            state_d  = ST_READ;
          end
        end
      end
      ST_READ: begin
        addr_b_d = dst_q;
        we_b_d   = 1'b1;
        addr_a_d = step_addr(addr_a_q, desc_q);
        dst_d    = step_addr(dst_q, desc_q);
        remain_d = remain_q - ADDR_WIDTH'(1);
        if (remain_q == '0) begin
          state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_a_q <= '0;
      dst_q    <= '0;
      addr_b_q <= '0;
      remain_q <= '0;
      desc_q   <= 1'b0;
      mode_q   <= MODE_COPY;
      fill_q   <= '0;
      we_b_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      dst_q    <= dst_d;
      addr_b_q <= addr_b_d;
      remain_q <= remain_d;
      desc_q   <= desc_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      we_b_q   <= we_b_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Port A is read-only; port B write data bypasses the read data straight through.
  always_comb begin
    busy       = busy_q;
    done       = done_q;
    mem_addr_a = addr_a_q;
    mem_we_a   = 1'b0;
    mem_data_a = '0;
    mem_addr_b = addr_b_q;
    mem_we_b   = we_b_q;
    mem_data_b = (mode_q == MODE_FILL) ? fill_q : mem_q_a;
  end

endmodule
